// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: FSM state encoding and width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Output beat stream of the burst reader: valid/ready with data and last flag.
// Latency: n/a (wires only).
// Backpressure: beat transfers when m_valid & m_ready; master holds m_data while stalled.
// Ports: m_valid, m_data, m_last driven by master; m_ready driven by slave.
interface fifo_burst_reader_if #(
  parameter int WIDTH = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry in-order output buffer; entry 0 is always the head.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: caller must not push when full without a simultaneous pop.
// Ports: clk/rst, push+push_dat (tail write), pop (head release), occ (0..2), head_dat.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_ok;

  // A pop on an empty buffer is ignored so occupancy can never underflow.
  assign pop_ok = pop & (occ_q != 2'd0);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({push, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_dat;
        else               e1_d = push_dat;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          e0_d = push_dat;
        end else begin
          e0_d = e1_q;
          e1_d = push_dat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ      = occ_q;
  assign head_dat = e0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a one-cycle-latency FIFO and streams the words as bursts with m_last on every BURST_LEN-th beat.
// Latency: first m_valid 3 cycles after en is sampled; then 1 beat/cycle.
// Backpressure: at most 2 words buffered plus in flight; fifo_rd_en stops once that budget is used.
// Ports: clk/rst, en (run request), fifo_empty/fifo_data/fifo_rd_en (FIFO read port), m (beat stream), busy.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      fifo_empty,
  input  logic [WIDTH-1:0]          fifo_data,
  output logic                      fifo_rd_en,
  fifo_burst_reader_if.master       m,
  output logic                      busy
);

  localparam int CNT_W = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             inflight_q, inflight_d;

  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic [WIDTH-1:0] head_dat;
  logic             valid;
  logic             pop;
  logic [31:0]      held;
  logic [31:0]      remain;
  logic             room;
  logic             continuing;
  logic             finishing;
  logic             limit_ok;

  // The word read last cycle is on fifo_data now, so the in-flight flag is the push strobe.
  fifo_out_buf #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat (fifo_data),
    .pop      (pop),
    .occ      (occ),
    .head_dat (head_dat)
  );

  assign valid     = (occ != 2'd0);
  assign pop       = valid & m.m_ready;
  assign m.m_valid = valid;
  assign m.m_data  = head_dat;
  assign m.m_last  = valid & (beat_cnt_q == LAST_BEAT);
  assign busy      = busy_q;

  always_comb begin
    held   = 32'(occ) + 32'(inflight_q);
    remain = 32'(BURST_LEN) - 32'(beat_cnt_q);
    // Count the word leaving this cycle as already gone so streaming stays at one beat per cycle.
    room   = (held - 32'(pop)) < 32'd2;

    continuing = (state_q == ST_RUN) & en;
    // When stopping, only fetch what the open burst still needs; a burst at
    // its boundary (count 0) needs nothing more.
    finishing  = (state_q == ST_FINISH) | ((state_q == ST_RUN) & ~en);
    limit_ok   = (beat_cnt_q != '0) & (held < remain);

    fifo_rd_en = room & (continuing | (finishing & limit_ok)) & ~fifo_empty;
  end

  always_comb begin
    inflight_d = fifo_rd_en;
    occ_nxt    = occ + {1'b0, inflight_q} - {1'b0, pop};

    beat_cnt_d = beat_cnt_q;
    if (pop) beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          if (beat_cnt_d != '0)                          state_d = ST_FINISH;
          else if ((occ_nxt == 2'd0) && !inflight_d)     state_d = ST_IDLE;
        end
      end
      ST_FINISH: begin
        if (pop && m.m_last) begin
          // Leftover buffered words (only possible if the stop came at a boundary
          // with words already fetched) are drained by RUN as a fresh burst.
          if (!en && (occ_nxt == 2'd0) && !inflight_d) state_d = ST_IDLE;
          else                                          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered from the current state, so busy trails the state by one cycle.
    busy_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: one instance with BURST_LEN=4, one with BURST_LEN=1.
// Each instance reads from a small queue-based FIFO model with a registered data output.
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic rd_en0, rd_en1;
  logic busy0, busy1;

  logic [7:0] fdata  [2] = '{8'h00, 8'h00};
  logic       fempty [2] = '{1'b1, 1'b1};
  logic       rd_s   [2] = '{1'b0, 1'b0};
  int         rd_cnt [2] = '{0, 0};
  logic [7:0] fq [2][$];
  logic [7:0] wq [2][$];

  int tests = 0;
  int fails = 0;

  fifo_burst_reader_if #(.WIDTH(8)) u_if0 ();
  fifo_burst_reader_if #(.WIDTH(8)) u_if1 ();

  fifo_burst_reader #(.WIDTH(8), .BURST_LEN(4)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .en         (en0),
    .fifo_empty (fempty[0]),
    .fifo_data  (fdata[0]),
    .fifo_rd_en (rd_en0),
    .m          (u_if0.master),
    .busy       (busy0)
  );

  fifo_burst_reader #(.WIDTH(8), .BURST_LEN(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en1),
    .fifo_empty (fempty[1]),
    .fifo_data  (fdata[1]),
    .fifo_rd_en (rd_en1),
    .m          (u_if1.master),
    .busy       (busy1)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so rd_en is settled by the falling edge.
  always @(negedge clk) begin
    rd_s[0] = rd_en0;
    rd_s[1] = rd_en1;
  end

  // FIFO model: read data registered on the edge, writes land on the edge after they are queued.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_s[k]) begin
        rd_cnt[k] = rd_cnt[k] + 1;
        if (fq[k].size() > 0) fdata[k] <= fq[k].pop_front();
      end
      while (wq[k].size() > 0) fq[k].push_back(wq[k].pop_front());
      fempty[k] <= (fq[k].size() == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a beat on instance 0 with m_ready held high, check it, let it transfer.
  task automatic take0(input string tag, input logic [7:0] ed, input logic el);
    int g;
    g = 0;
    while (!u_if0.m_valid && g < 50) begin
      tick();
      g++;
    end
    check({tag, "_vld"},  32'(u_if0.m_valid), 32'd1);
    check({tag, "_dat"},  32'(u_if0.m_data),  32'(ed));
    check({tag, "_last"}, 32'(u_if0.m_last),  32'(el));
    tick();
  endtask

  initial begin
    int base;
    int n;
    int g;
    logic [7:0] exp_b;

    u_if0.m_ready = 1'b0;
    u_if1.m_ready = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_rd_en", 32'(rd_en0),        32'd0);
    check("rst_vld",   32'(u_if0.m_valid), 32'd0);
    check("rst_dat",   32'(u_if0.m_data),  32'd0);
    check("rst_last",  32'(u_if0.m_last),  32'd0);
    check("rst_busy",  32'(busy0),         32'd0);
    rst = 1'b1;
    tick();

    // ---- basic flow and en-to-data latency ----
    wq[0].push_back(8'hAA);
    wq[0].push_back(8'hBB);
    wq[0].push_back(8'hCC);
    wq[0].push_back(8'hDD);
    tick();
    u_if0.m_ready = 1'b1;
    en0 = 1'b1;
    tick();
    check("lat_c1_rd_en", 32'(rd_en0),        32'd1);
    check("lat_c1_vld",   32'(u_if0.m_valid), 32'd0);
    tick();
    check("lat_c2_vld",   32'(u_if0.m_valid), 32'd0);
    tick();
    check("lat_c3_vld",   32'(u_if0.m_valid), 32'd1);
    check("basic_busy",   32'(busy0),         32'd1);
    take0("basic0", 8'hAA, 1'b0);
    take0("basic1", 8'hBB, 1'b0);
    take0("basic2", 8'hCC, 1'b0);
    take0("basic3", 8'hDD, 1'b1);
    en0 = 1'b0;
    repeat (3) tick();
    check("basic_idle_busy", 32'(busy0),         32'd0);
    check("basic_idle_vld",  32'(u_if0.m_valid), 32'd0);

    // ---- backpressure ----
    for (int i = 0; i < 8; i++) wq[0].push_back(8'(8'h10 + i));
    u_if0.m_ready = 1'b0;
    tick();
    base = rd_cnt[0];
    en0 = 1'b1;
    repeat (4) tick();
    check("bp_vld_early", 32'(u_if0.m_valid), 32'd1);
    check("bp_dat_early", 32'(u_if0.m_data),  32'h10);
    repeat (8) tick();
    check("bp_rd_pulses", 32'(rd_cnt[0] - base), 32'd2);
    check("bp_rd_en_low", 32'(rd_en0),           32'd0);
    check("bp_dat_held",  32'(u_if0.m_data),     32'h10);
    u_if0.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) take0("bp", 8'(8'h10 + i), (i % 4) == 3);
    en0 = 1'b0;
    repeat (3) tick();
    check("bp_idle_busy", 32'(busy0), 32'd0);

    // ---- FIFO runs dry mid-burst ----
    wq[0].push_back(8'hAA);
    wq[0].push_back(8'hBB);
    tick();
    en0 = 1'b1;
    take0("dry0", 8'hAA, 1'b0);
    take0("dry1", 8'hBB, 1'b0);
    check("dry_vld",   32'(u_if0.m_valid), 32'd0);
    check("dry_rd_en", 32'(rd_en0),        32'd0);
    repeat (5) tick();
    check("dry_vld_hold", 32'(u_if0.m_valid), 32'd0);
    check("dry_busy",     32'(busy0),         32'd1);
    wq[0].push_back(8'hCC);
    wq[0].push_back(8'hDD);
    take0("dry2", 8'hCC, 1'b0);
    take0("dry3", 8'hDD, 1'b1);
    en0 = 1'b0;
    repeat (3) tick();

    // ---- en dropped mid-burst with 6 words available ----
    for (int i = 0; i < 6; i++) wq[0].push_back(8'(8'h20 + i));
    tick();
    base = rd_cnt[0];
    en0 = 1'b1;
    take0("ms0", 8'h20, 1'b0);
    take0("ms1", 8'h21, 1'b0);
    en0 = 1'b0;
    take0("ms2", 8'h22, 1'b0);
    take0("ms3", 8'h23, 1'b1);
    repeat (6) tick();
    check("ms_rd_pulses", 32'(rd_cnt[0] - base), 32'd4);
    check("ms_words_left", 32'(fq[0].size()),    32'd2);
    check("ms_busy",      32'(busy0),            32'd0);
    check("ms_vld",       32'(u_if0.m_valid),    32'd0);

    // ---- asynchronous reset with two words buffered ----
    for (int i = 0; i < 8; i++) wq[0].push_back(8'(8'h30 + i));
    tick();
    en0 = 1'b1;
    take0("rs0", 8'h24, 1'b0);
    take0("rs1", 8'h25, 1'b0);
    u_if0.m_ready = 1'b0;
    repeat (4) tick();
    check("rs_pre_vld", 32'(u_if0.m_valid), 32'd1);
    check("rs_pre_dat", 32'(u_if0.m_data),  32'h30);
    #2 rst = 1'b0;
    #1;
    check("rs_async_rd_en", 32'(rd_en0),        32'd0);
    check("rs_async_vld",   32'(u_if0.m_valid), 32'd0);
    check("rs_async_dat",   32'(u_if0.m_data),  32'd0);
    check("rs_async_last",  32'(u_if0.m_last),  32'd0);
    check("rs_async_busy",  32'(busy0),         32'd0);
    tick();
    rst = 1'b1;
    u_if0.m_ready = 1'b1;
    take0("rs2", 8'h32, 1'b0);
    en0 = 1'b0;
    take0("rs3", 8'h33, 1'b0);
    take0("rs4", 8'h34, 1'b0);
    take0("rs5", 8'h35, 1'b1);
    repeat (3) tick();
    check("rs_post_busy", 32'(busy0), 32'd0);

    // ---- BURST_LEN=1 with random m_ready over 64 words ----
    for (int i = 0; i < 64; i++) wq[1].push_back(8'(i * 7 + 3));
    tick();
    en1 = 1'b1;
    n = 0;
    g = 0;
    while (n < 64 && g < 2000) begin
      u_if1.m_ready = 1'($urandom_range(0, 1));
      if (u_if1.m_valid && u_if1.m_ready) begin
        exp_b = 8'(n * 7 + 3);
        check("b1_dat",  32'(u_if1.m_data), 32'(exp_b));
        check("b1_last", 32'(u_if1.m_last), 32'd1);
        n++;
      end
      tick();
      g++;
    end
    check("b1_count", 32'(n), 32'd64);
    u_if1.m_ready = 1'b0;
    en1 = 1'b0;
    repeat (4) tick();
    check("b1_rd_total", 32'(rd_cnt[1]), 32'd64);
    check("b1_busy",     32'(busy1),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
